// File: rtl/berger_pkg.sv
// Shared definitions for the Berger-coded word memory read-side checker.
// A stored word is {payload[7:0], check[3:0]}; the check field holds the
// number of zero bits in the payload.
package berger_pkg;

    localparam int DATA_W = 8;
    localparam int CHK_W  = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    // Full stored word width and the width of the violation counter, which
    // must be able to hold DEPTH itself (every entry failing).
    localparam int WORD_W    = DATA_W + CHK_W;
    localparam int ERR_CNT_W = ADDR_W + 1;

    // Background sweep phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scrub_state_e;

    // Count of zero bits in a payload; this is the value a good word carries
    // in its check field. The result never exceeds DATA_W.
    function automatic logic [CHK_W-1:0] berger_zeros(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (!data[i]) begin
                n = n + CHK_W'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/berger_check.sv
// Combinational Berger check of one stored word. Check values above DATA_W
// can never equal a zero count, so they always report an error.
module berger_check
    import berger_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              err
);

    logic [DATA_W-1:0] payload;
    logic [CHK_W-1:0]  check;

    // Split the word and compare the stored check against the recomputed one.
    always_comb begin
        payload = word[WORD_W-1:CHK_W];
        check   = word[CHK_W-1:0];
        err     = (check != berger_zeros(payload));
    end

endmodule

// File: rtl/berger_scrub_checker.sv
// Read-side checker for the 16-entry Berger-coded word memory.
// Owns the memory read address: host reads take priority, otherwise the
// background sweep drives its own address while scanning.
// Host reads get a registered response one cycle later; the sweep counts
// violations and remembers the first failing address.
// Widths come from berger_pkg.
// Optional macro BERGER_ERR_IRQ_EN adds irq_clr / err_irq, a sticky error
// flag raised by any failing check (host or sweep).
module berger_scrub_checker
    import berger_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [WORD_W-1:0]    mem_data,
    input  logic                 rd_req,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic                 rd_valid,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_err,
    input  logic                 scrub_start,
    output logic                 scrub_busy,
    output logic                 scrub_done,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_err_addr
`ifdef BERGER_ERR_IRQ_EN
    ,
    input  logic                 irq_clr,
    output logic                 err_irq
`endif
);

    scrub_state_e state_q, state_d;

    logic [ADDR_W-1:0]    scrub_addr_q, scrub_addr_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [ADDR_W-1:0]    first_err_addr_q, first_err_addr_d;

    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 rd_err_q, rd_err_d;

    logic                 chk_err;

    // Only one word is read per cycle, so a single checker on the read port
    // serves both host reads and the sweep.
    berger_check u_check (
        .word (mem_data),
        .err  (chk_err)
    );

    // Sweep state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep next-state: a host read in SCAN stalls the sweep for that cycle,
    // and the sweep finishes once the last entry has been checked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (scrub_start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!rd_req && (scrub_addr_q == ADDR_W'(DEPTH - 1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sweep outputs and the shared read-address mux (host read wins).
    always_comb begin
        scrub_busy = (state_q == SCAN) || (state_q == DONE);
        scrub_done = (state_q == DONE);
        if (rd_req) begin
            mem_addr = rd_addr;
        end else if (state_q == SCAN) begin
            mem_addr = scrub_addr_q;
        end else begin
            mem_addr = '0;
        end
    end

    // Sweep datapath: results are cleared when a sweep starts and held in
    // IDLE afterwards so software can read them at leisure.
    always_comb begin
        scrub_addr_d     = scrub_addr_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        case (state_q)
            IDLE: begin
                if (scrub_start) begin
                    scrub_addr_d     = '0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                end
            end
            SCAN: begin
                if (!rd_req) begin
                    if (chk_err) begin
                        if (err_count_q == '0) begin
                            first_err_addr_d = scrub_addr_q;
                        end
                        err_count_d = err_count_q + ERR_CNT_W'(1);
                    end
                    scrub_addr_d = scrub_addr_q + ADDR_W'(1);
                end
            end
            default: begin
                scrub_addr_d = scrub_addr_q;
            end
        endcase
    end

    // Sweep datapath registers; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_addr_q     <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            scrub_addr_q     <= scrub_addr_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    // Host response: capture payload and check result of the word read now,
    // presented next cycle. Data holds between responses.
    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        if (rd_req) begin
            rd_data_d = mem_data[WORD_W-1:CHK_W];
            rd_err_d  = chk_err;
        end
    end

    // Host response registers; a reset cycle swallows a concurrent request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
        end
    end

`ifdef BERGER_ERR_IRQ_EN
    logic err_irq_q, err_irq_d;
    logic irq_set;

    // Sticky error flag: any check that actually ran this cycle and failed
    // sets it, and a set in the same cycle as a clear takes precedence.
    always_comb begin
        irq_set   = chk_err && (rd_req || (state_q == SCAN));
        err_irq_d = irq_set || (err_irq_q && !irq_clr);
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_irq_q <= 1'b0;
        end else begin
            err_irq_q <= err_irq_d;
        end
    end

    assign err_irq = err_irq_q;
`endif

    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_err         = rd_err_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_berger_scrub_checker.sv
// Self-checking bench for berger_scrub_checker. A behavioural model of the
// memory and checker is compared against the DUT on every falling edge, and
// directed scenarios pin key values with hand-computed literals.
module tb_berger_scrub_checker;
    import berger_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ADDR_W-1:0]    mem_addr;
    logic [WORD_W-1:0]    mem_data;
    logic                 rd_req;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_valid;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_err;
    logic                 scrub_start;
    logic                 scrub_busy;
    logic                 scrub_done;
    logic [ERR_CNT_W-1:0] err_count;
    logic [ADDR_W-1:0]    first_err_addr;
`ifdef BERGER_ERR_IRQ_EN
    logic                 irq_clr;
    logic                 err_irq;
`endif

    logic [WORD_W-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Asynchronous-read memory model.
    assign mem_data = mem[mem_addr];

    berger_scrub_checker dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_err         (rd_err),
        .scrub_start    (scrub_start),
        .scrub_busy     (scrub_busy),
        .scrub_done     (scrub_done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
`ifdef BERGER_ERR_IRQ_EN
        ,
        .irq_clr        (irq_clr),
        .err_irq        (err_irq)
`endif
    );

    // A word is bad unless its low nibble equals the payload's zero count.
    function automatic bit word_bad(input logic [WORD_W-1:0] w);
        return int'(w[3:0]) != (8 - $countones(w[11:4]));
    endfunction

    task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_phase = 0;   // 0 idle, 1 scanning, 2 finishing
    int              m_visits = 0;  // entries checked so far in this sweep
    bit              m_bad [DEPTH];
    bit              m_valid = 0;
    logic [7:0]      m_data = '0;
    bit              m_err = 0;
    bit              m_irq = 0;
    bit              model_live = 0;

    always @(posedge clk) begin
        bit set_irq;
        set_irq = 0;
        if (rst) begin
            m_phase  = 0;
            m_visits = 0;
            m_valid  = 0;
            m_irq    = 0;
            foreach (m_bad[a]) m_bad[a] = 0;
        end else begin
            m_valid = rd_req;
            if (rd_req) begin
                m_data = mem[rd_addr][11:4];
                m_err  = word_bad(mem[rd_addr]);
                if (m_err) set_irq = 1;
            end
            case (m_phase)
                0: if (scrub_start) begin
                    m_phase  = 1;
                    m_visits = 0;
                    foreach (m_bad[a]) m_bad[a] = 0;
                end
                1: if (!rd_req) begin
                    m_bad[m_visits] = word_bad(mem[m_visits]);
                    if (m_bad[m_visits]) set_irq = 1;
                    m_visits++;
                    if (m_visits == DEPTH) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
`ifdef BERGER_ERR_IRQ_EN
            m_irq = set_irq || (m_irq && !irq_clr);
`endif
        end
        model_live = 1;
    end

    // Compare process: every falling edge once the model has seen a clock.
    always @(negedge clk) begin
        if (model_live) begin
            int exp_cnt;
            int exp_first;
            int exp_addr;
            exp_cnt   = 0;
            exp_first = -1;
            for (int a = 0; a < m_visits; a++) begin
                if (m_bad[a]) begin
                    exp_cnt++;
                    if (exp_first < 0) exp_first = a;
                end
            end
            if (exp_first < 0) exp_first = 0;
            exp_addr = rd_req ? int'(rd_addr) : (m_phase == 1 ? m_visits : 0);

            checkOutput("rd_valid", 32'(rd_valid), 32'(m_valid));
            if (m_valid) begin
                checkOutput("rd_data", 32'(rd_data), 32'(m_data));
                checkOutput("rd_err", 32'(rd_err), 32'(m_err));
            end
            checkOutput("scrub_busy", 32'(scrub_busy), 32'(m_phase != 0));
            checkOutput("scrub_done", 32'(scrub_done), 32'(m_phase == 2));
            checkOutput("err_count", 32'(err_count), exp_cnt);
            checkOutput("first_err_addr", 32'(first_err_addr), exp_first);
            checkOutput("mem_addr", 32'(mem_addr), exp_addr);
`ifdef BERGER_ERR_IRQ_EN
            checkOutput("err_irq", 32'(err_irq), 32'(m_irq));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input bit req, input logic [ADDR_W-1:0] addr,
                                 input bit start, input bit r);
        @(posedge clk);
        #1;
        rd_req      = req;
        rd_addr     = addr;
        scrub_start = start;
        rst         = r;
    endtask

    // Runs one sweep. Host reads are requested in sweep cycles
    // [stall_at, stall_at+stall_len); reset is pulsed in cycle rst_at.
    // lat is the sweep cycle in which scrub_done appears, or -1.
    task automatic runSweep(input int stall_at, input int stall_len,
                            input int rst_at, output int lat);
        applyStimulus(0, '0, 1, 0);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            bit req;
            req = (c >= stall_at) && (c < stall_at + stall_len);
            applyStimulus(req, ADDR_W'(c), 0, (c == rst_at));
            @(negedge clk);
            if (scrub_done) begin
                lat = c;
                break;
            end
            if (rst_at > 0 && c == rst_at + 1) begin
                checkOutput("abort busy", 32'(scrub_busy), 0);
                checkOutput("abort err_count", 32'(err_count), 0);
                checkOutput("abort first_err_addr", 32'(first_err_addr), 0);
                checkOutput("abort rd_valid", 32'(rd_valid), 0);
            end
        end
        applyStimulus(0, '0, 0, 0);
    endtask

    initial begin
        int lat;
        rst         = 1'b1;
        rd_req      = 1'b0;
        rd_addr     = '0;
        scrub_start = 1'b0;
`ifdef BERGER_ERR_IRQ_EN
        irq_clr     = 1'b0;
`endif
        foreach (mem[a]) mem[a] = 12'h008;
        mem[3] = 12'hFF0;
        mem[4] = 12'h005;

        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        checkOutput("reset rd_valid", 32'(rd_valid), 0);
        checkOutput("reset rd_data", 32'(rd_data), 0);
        checkOutput("reset busy", 32'(scrub_busy), 0);
        checkOutput("reset err_count", 32'(err_count), 0);
        checkOutput("reset mem_addr", 32'(mem_addr), 0);

        // Host reads: good word then bad word, back to back.
        applyStimulus(1, 4'd3, 0, 0);
        applyStimulus(1, 4'd4, 0, 0);
        @(negedge clk);
        checkOutput("read3 valid", 32'(rd_valid), 1);
        checkOutput("read3 data", 32'(rd_data), 32'hFF);
        checkOutput("read3 err", 32'(rd_err), 0);
        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        checkOutput("read4 valid", 32'(rd_valid), 1);
        checkOutput("read4 data", 32'(rd_data), 32'h00);
        checkOutput("read4 err", 32'(rd_err), 1);
        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        checkOutput("idle valid", 32'(rd_valid), 0);

        // Reset in the same cycle as a request swallows the response.
        applyStimulus(1, 4'd3, 0, 1);
        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        checkOutput("rst+req valid", 32'(rd_valid), 0);

`ifdef BERGER_ERR_IRQ_EN
        applyStimulus(1, 4'd4, 0, 0);
        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        checkOutput("irq set", 32'(err_irq), 1);
        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        checkOutput("irq sticky", 32'(err_irq), 1);
        applyStimulus(1, 4'd4, 0, 0);
        irq_clr = 1'b1;
        applyStimulus(0, '0, 0, 0);
        irq_clr = 1'b0;
        @(negedge clk);
        checkOutput("irq set beats clear", 32'(err_irq), 1);
        applyStimulus(0, '0, 0, 0);
        irq_clr = 1'b1;
        applyStimulus(0, '0, 0, 0);
        irq_clr = 1'b0;
        @(negedge clk);
        checkOutput("irq cleared", 32'(err_irq), 0);
`endif

        // All-good memory sweep.
        mem[4] = 12'h008;
        runSweep(0, 0, 0, lat);
        checkOutput("clean sweep latency", lat, 17);
        checkOutput("clean sweep err_count", 32'(err_count), 0);

        // Two bad entries.
        mem[5]  = 12'h005;
        mem[12] = 12'h005;
        runSweep(0, 0, 0, lat);
        checkOutput("bad sweep latency", lat, 17);
        checkOutput("bad sweep err_count", 32'(err_count), 2);
        checkOutput("bad sweep first", 32'(first_err_addr), 5);

        // Three stalled cycles mid-sweep.
        runSweep(6, 3, 0, lat);
        checkOutput("stall sweep latency", lat, 20);
        checkOutput("stall sweep err_count", 32'(err_count), 2);
        checkOutput("stall sweep first", 32'(first_err_addr), 5);

        // Reset in SCAN cycle 8 aborts with no done pulse.
        runSweep(0, 0, 8, lat);
        checkOutput("aborted sweep done", lat, -1);

        // A fresh sweep after the abort completes normally.
        runSweep(0, 0, 0, lat);
        checkOutput("resweep latency", lat, 17);
        checkOutput("resweep err_count", 32'(err_count), 2);
        checkOutput("resweep first", 32'(first_err_addr), 5);

        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/berger_scrub_checker.md
# berger_scrub_checker

Read-side checker for the 16-entry Berger-coded word memory. Sits directly downstream of the memory's asynchronous read port and owns its address input. It serves host reads with a one-cycle registered response carrying data and an error flag. It also runs a background scrub sweep over all entries that counts Berger violations and records the first failing address.

## Interface
Parameters:
- DATA_W, 8, payload bits per word (word[11:4])
- CHK_W, 4, Berger check bits (word[3:0])
- DEPTH, 16, memory entries
- ADDR_W, 4, address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- mem_addr  out  ADDR_W  address driven to the memory read port
- mem_data  in  DATA_W+CHK_W  combinational read data for mem_addr
- rd_req  in  1  host read request, one-cycle qualifier
- rd_addr  in  ADDR_W  host read address
- rd_valid  out  1  host response valid, one-cycle pulse
- rd_data  out  DATA_W  payload of the word read
- rd_err  out  1  Berger check failed for the word read
- scrub_start  in  1  begin a full sweep
- scrub_busy  out  1  sweep in progress
- scrub_done  out  1  one-cycle pulse at sweep end
- err_count  out  ADDR_W+1  violations found in the last or current sweep
- first_err_addr  out  ADDR_W  lowest-order address (first visited) that failed; meaningful when err_count != 0

## Operation
- Berger rule: check = number of zero bits in word[11:4]. A word is good only if word[3:0] equals that count. Check values 9..15 are always errors.
  - Examples: 0xFF0 good. 0x008 good. 0xA54 good. 0x005 bad.
- Address mux: if rd_req=1, mem_addr=rd_addr. Otherwise, in SCAN, mem_addr=scrub_addr. Otherwise mem_addr=0.
- Host read: always accepted, with no ready signal.
  - Next cycle: rd_valid=1, rd_data=word[11:4], rd_err=check result.
  - Back-to-back requests give back-to-back responses.
- FSM states:
  - IDLE: scrub_start=1 -> SCAN. On entry, clear err_count and first_err_addr, and set scrub_addr=0.
  - SCAN: in cycles with rd_req=0, check mem_data at scrub_addr. On failure:
    - If err_count==0, set first_err_addr=scrub_addr.
    - Increment err_count.
    - Then scrub_addr+1.
    - At scrub_addr==15 after check -> DONE.
  - SCAN, cycles with rd_req=1: scrub stalls. scrub_addr and counters are unchanged, and that entry is checked later.
  - DONE: scrub_done=1 for one cycle -> IDLE.
- scrub_start in SCAN or DONE is ignored. scrub_start in the IDLE cycle right after DONE starts a new sweep.
- err_count is at most 16 (5 bits) and cannot overflow.
- scrub_busy=1 in SCAN and DONE.
- err_count and first_err_addr hold their values in IDLE until the next scrub_start.

## Timing
- Reset values: rd_valid=0, rd_data=0, rd_err=0, scrub_busy=0, scrub_done=0, err_count=0, first_err_addr=0. State is IDLE and scrub_addr=0. With rd_req=0, mem_addr=0.
- Host read latency: 1 cycle, request to rd_valid.
- Uncontested sweep: scrub_start at cycle T -> SCAN from T+1 through T+16 -> scrub_done at T+17.
  - Each host read during SCAN adds exactly 1 cycle.
- rst during SCAN aborts the sweep immediately. Counters are cleared, and no scrub_done is produced.
- rst in the same cycle as rd_req: no response is produced.
- A memory write to an address during a sweep: the checker sees whatever the memory returns in the cycle it visits that address. No coherence is provided.

## Configuration
- BERGER_ERR_IRQ_EN defined: adds input irq_clr (1 bit) and output err_irq (1 bit, reset 0).
  - err_irq is set by any failing check, host or scrub.
  - It is sticky until irq_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Not defined: neither port exists, and behaviour is otherwise identical.

## Structure
- Shared package berger_pkg contains:
  - DATA_W, CHK_W, DEPTH, ADDR_W
  - scrub state enum {IDLE, SCAN, DONE}
  - function berger_zeros(data) returning the CHK_W-bit zero count
- One sub-module, berger_check: combinational. It takes a word and outputs err (check != berger_zeros(data)). It is instantiated once on mem_data, since only one read is checked per cycle.

## Test plan
- Reset, then host reads addr 3 holding 0xFF0 -> next cycle rd_valid=1, rd_data=0xFF, rd_err=0. A read of 0x005 -> rd_err=1.
- Memory all good (data 0x00, check 8 -> 0x008), scrub_start -> scrub_done exactly 17 cycles later, err_count=0.
- Bad words (0x005) at addrs 5 and 12, sweep -> err_count=2, first_err_addr=5.
- Sweep with rd_req held for 3 cycles mid-sweep -> scrub_done at +20, every host response correct, counts as in the no-stall case.
- rst asserted at SCAN cycle 8 -> all outputs at reset values next cycle, no scrub_done. A new scrub_start completes normally.
- BERGER_ERR_IRQ_EN: bad host read -> err_irq=1 and stays 1. Simultaneous irq_clr and bad check -> err_irq stays 1. irq_clr alone -> 0.
